// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bus for pipe_skid_reg: upstream (in_*) and downstream (out_*) sides.
// The flush signal exists only when PIPE_FLUSH_EN is defined.
interface pipe_skid_reg_if #(
    parameter int width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_data;
`ifdef PIPE_FLUSH_EN
    logic             flush;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline register with a one-beat skid slot; in_ready is a flop.
// Optional PIPE_FLUSH_EN adds a flush input that drops all buffered beats.
module pipe_skid_reg #(
    parameter int width = 32
) (
    input  logic            clk,
    input  logic            reset,
    pipe_skid_reg_if.slave  bus
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [width-1:0] r_main_data;
    logic [width-1:0] r_skid_data;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [1:0]       w_state;

    assign w_in_xfer  = bus.in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    // The occupancy flags themselves encode the state.
    assign w_state    = {r_skid_valid, r_out_valid};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
`ifdef PIPE_FLUSH_EN
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
`endif
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_data <= bus.in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_data <= bus.in_data;
                    end else if (w_in_xfer) begin
                        r_skid_data  <= bus.in_data;
                        r_skid_valid <= 1'b1;
                        r_in_ready   <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    // Skid without main is unreachable; fall back to EMPTY.
                    r_skid_valid <= 1'b0;
                    r_out_valid  <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed plus random test of pipe_skid_reg against a queue scoreboard.
// Flush steps are compiled in only when PIPE_FLUSH_EN is defined.
module tb_pipe_skid_reg;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mq[$];

    pipe_skid_reg_if #(.width(32)) bus ();

    pipe_skid_reg #(.width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0)
            chk({tag, ".out_data"}, bus.out_data, mq[0]);
    endtask

    // Scoreboard update from the bench's own occupancy, then one clock.
    task automatic tick(input string tag);
        bit in_acc;
        bit out_acc;
        in_acc  = bus.in_valid && (mq.size() < 2);
        out_acc = bus.out_ready && (mq.size() > 0);
        if (reset) begin
            mq.delete();
`ifdef PIPE_FLUSH_EN
        end else if (bus.flush) begin
            mq.delete();
`endif
        end else begin
            if (out_acc) begin
                $display("%0t out %h", $time, mq[0]);
                void'(mq.pop_front());
            end
            if (in_acc) begin
                $display("%0t in  %h", $time, bus.in_data);
                mq.push_back(bus.in_data);
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    initial begin
        reset = 1'b1;
`ifdef PIPE_FLUSH_EN
        bus.flush = 1'b0;
`endif
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        tick("reset0");
        chk("reset0.data", bus.out_data, 32'h0);
        tick("reset1");
        chk("reset1.data", bus.out_data, 32'h0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick("idle");
            chk("idle.data", bus.out_data, 32'h0);
        end

        // Streaming at full rate.
        drive(1'b1, 32'h1, 1'b1); tick("stream1");
        drive(1'b1, 32'h2, 1'b1); tick("stream2");
        drive(1'b1, 32'h3, 1'b1); tick("stream3");
        drive(1'b0, 32'h0, 1'b1); tick("stream_drain");
        tick("stream_idle");

        // Back-pressure fills the skid; 0xC must wait.
        drive(1'b1, 32'hA, 1'b0); tick("bp_a");
        drive(1'b1, 32'hB, 1'b0); tick("bp_b");
        chk("bp.hold_a", bus.out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b0); tick("bp_c_blocked");
        tick("bp_c_blocked2");
        chk("bp.still_a", bus.out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b1); tick("bp_release");
        tick("bp_c_accept");
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick("bp_drain");

        // Simultaneous in/out while BUSY.
        drive(1'b1, 32'h5, 1'b0); tick("sim_5");
        drive(1'b1, 32'h6, 1'b1); tick("sim_6");
        chk("sim.data", bus.out_data, 32'h6);
        drive(1'b0, 32'h0, 1'b1); tick("sim_drain");

        // Reset while FULL discards both beats.
        drive(1'b1, 32'h11, 1'b0); tick("rf_11");
        drive(1'b1, 32'h22, 1'b0); tick("rf_22");
        reset = 1'b1;
        drive(1'b1, 32'h99, 1'b1); tick("rf_reset");
        chk("rf.data", bus.out_data, 32'h0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick("rf_after");

`ifdef PIPE_FLUSH_EN
        drive(1'b1, 32'h33, 1'b0); tick("fl_33");
        drive(1'b1, 32'h44, 1'b0); tick("fl_44");
        bus.flush = 1'b1;
        drive(1'b1, 32'h55, 1'b1); tick("fl_flush");
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick("fl_after");
`endif

        // Random traffic with random stalls.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
            tick("rand");
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
